// File: rtl/pc_stack_pkg.sv
// ============================================================================
// Module  : pc_stack_pkg
// Purpose : Shared definitions for the PC save/restore stack unit. Holds the
//           FSM state encoding, default stack bounds and the number of 16-bit
//           words in each stack frame.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pc_stack_pkg;

  // Default stack geometry for a 20-bit word-addressed data memory
  localparam int unsigned    ADDR_W_DEFAULT   = 20;
  localparam logic [19:0]    SP_INIT_DEFAULT  = 20'hFFFFF;
  localparam logic [19:0]    SP_LIMIT_DEFAULT = 20'h00800;

  // Frame sizes in 16-bit words: CALL/RET move the PC only, INT/RTI add CCR
  localparam int unsigned    PC_WORDS  = 2;
  localparam int unsigned    INT_WORDS = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_F = 3'd1,
    ST_PUSH_H = 3'd2,
    ST_PUSH_L = 3'd3,
    ST_POP_L  = 3'd4,
    ST_POP_H  = 3'd5,
    ST_POP_F  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

endpackage : pc_stack_pkg

`default_nettype wire

// File: rtl/pc_stack_unit.sv
// ============================================================================
// Module  : pc_stack_unit
// Purpose : Saves the 32-bit return PC (and optionally the 3-bit CCR) to the
//           data-memory stack as 16-bit words on CALL/INT, and restores them
//           on RET/RTI. Owns the stack pointer; stalls the pipeline while busy.
// Ports   : clk, rst (async, active low)
//           push_req/pop_req/with_flags/pc_in/flags_in  - request side
//           mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready - memory
//           busy/done/err  - status; pc_out/flags_out - restored values
//           sp_out         - current stack pointer
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(SP_INIT_DEFAULT),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              with_flags,
  input  logic [31:0]       pc_in,
  input  logic [2:0]        flags_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       pc_out,
  output logic [2:0]        flags_out,
  output logic [ADDR_W-1:0] sp_out
);

  // Frame sizes widened by one bit so bound checks cannot wrap
  localparam logic [ADDR_W:0] N_PC  = (ADDR_W+1)'(PC_WORDS);
  localparam logic [ADDR_W:0] N_INT = (ADDR_W+1)'(INT_WORDS);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic                wf_q, wf_d;           // frame includes CCR word
  logic [31:0]         pc_sv_q, pc_sv_d;     // PC captured for push
  logic [2:0]          fl_sv_q, fl_sv_d;     // CCR captured for push
  logic [31:0]         pc_out_q, pc_out_d;
  logic [2:0]          fl_out_q, fl_out_d;
  logic                err_q, err_d;

  logic [ADDR_W:0]     w_n;
  logic                w_push_ovf;
  logic                w_pop_unf;

  // Bound checks in ADDR_W+1 bits:
  //   overflow  : SP - n + 1 < SP_LIMIT  rewritten as  SP + 1 < SP_LIMIT + n
  //   underflow : SP + n > SP_INIT
  always_comb begin
    w_n        = with_flags ? N_INT : N_PC;
    w_push_ovf = ({1'b0, sp_q} + {{ADDR_W{1'b0}}, 1'b1}) < ({1'b0, SP_LIMIT} + w_n);
    w_pop_unf  = ({1'b0, sp_q} + w_n) > {1'b0, SP_INIT};
  end

  // Next-state logic; mem_ready only matters in access states where
  // mem_req is asserted, so it directly qualifies completion there.
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    wf_d     = wf_q;
    pc_sv_d  = pc_sv_q;
    fl_sv_d  = fl_sv_q;
    pc_out_d = pc_out_q;
    fl_out_d = fl_out_q;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (push_req) begin
          if (w_push_ovf) begin
            err_d = 1'b1;
          end else begin
            wf_d    = with_flags;
            pc_sv_d = pc_in;
            fl_sv_d = flags_in;
            state_d = with_flags ? ST_PUSH_F : ST_PUSH_H;
          end
        end else if (pop_req) begin
          if (w_pop_unf) begin
            err_d = 1'b1;
          end else begin
            wf_d    = with_flags;
            state_d = ST_POP_L;
          end
        end
      end
      ST_PUSH_F: if (mem_ready) begin
        sp_d    = sp_q - ONE;
        state_d = ST_PUSH_H;
      end
      ST_PUSH_H: if (mem_ready) begin
        sp_d    = sp_q - ONE;
        state_d = ST_PUSH_L;
      end
      ST_PUSH_L: if (mem_ready) begin
        sp_d    = sp_q - ONE;
        state_d = ST_DONE;
      end
      ST_POP_L: if (mem_ready) begin
        sp_d            = sp_q + ONE;
        pc_out_d[15:0]  = mem_rdata;
        state_d         = ST_POP_H;
      end
      ST_POP_H: if (mem_ready) begin
        sp_d            = sp_q + ONE;
        pc_out_d[31:16] = mem_rdata;
        state_d         = wf_q ? ST_POP_F : ST_DONE;
      end
      ST_POP_F: if (mem_ready) begin
        sp_d     = sp_q + ONE;
        fl_out_d = mem_rdata[2:0];
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and stack pointer share one register process
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sp_q     <= SP_INIT;
      wf_q     <= 1'b0;
      pc_sv_q  <= 32'h0;
      fl_sv_q  <= 3'h0;
      pc_out_q <= 32'h0;
      fl_out_q <= 3'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      wf_q     <= wf_d;
      pc_sv_q  <= pc_sv_d;
      fl_sv_q  <= fl_sv_d;
      pc_out_q <= pc_out_d;
      fl_out_q <= fl_out_d;
      err_q    <= err_d;
    end
  end

  // Address/data mux. Pushes write at SP; pops read one above SP because
  // the registered SP only advances once each read completes.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 16'h0;
    case (state_q)
      ST_PUSH_F: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = {13'b0, fl_sv_q};
      end
      ST_PUSH_H: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = pc_sv_q[31:16];
      end
      ST_PUSH_L: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = pc_sv_q[15:0];
      end
      ST_POP_L, ST_POP_H, ST_POP_F: begin
        mem_req  = 1'b1;
        mem_addr = sp_q + ONE;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign pc_out    = pc_out_q;
  assign flags_out = fl_out_q;
  assign sp_out    = sp_q;

endmodule : pc_stack_unit

`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
// ============================================================================
// Module  : tb_pc_stack_unit
// Purpose : Self-checking bench for pc_stack_unit. Table of push/pop records
//           plus hand sequences for wait states, dual requests and reset.
//           Memory accesses are checked against an expected-access queue.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_stack_unit;

  logic        clk;
  logic        rst;
  logic        push_req, pop_req, with_flags;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic        mem_req, mem_we, mem_ready;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, done, err;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  logic [19:0] sp_out;

  pc_stack_unit #(
    .ADDR_W  (20),
    .SP_INIT (20'hFFFFF),
    .SP_LIMIT(20'hFFFF6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req),
    .pop_req   (pop_req),
    .with_flags(with_flags),
    .pc_in     (pc_in),
    .flags_in  (flags_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pc_out    (pc_out),
    .flags_out (flags_out),
    .sp_out    (sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small memory covering the top 32 words of the address space
  logic [15:0] tb_mem [0:31];
  assign mem_rdata = tb_mem[mem_addr[4:0]];
  always @(posedge clk)
    if (rst && mem_req && mem_we && mem_ready)
      tb_mem[mem_addr[4:0]] <= mem_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard of expected memory accesses
  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] data;
  } acc_t;
  acc_t exp_q[$];
  logic [19:0] m_sp;

  always @(negedge clk) begin
    acc_t a;
    if (rst && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_access: got addr %h we %b expected none", mem_addr, mem_we);
      end else begin
        a = exp_q.pop_front();
        chk("acc_we", {31'b0, mem_we}, {31'b0, a.we});
        chk("acc_addr", {12'b0, mem_addr}, {12'b0, a.addr});
        if (a.we) chk("acc_wdata", {16'b0, mem_wdata}, {16'b0, a.data});
      end
    end
  end

  typedef struct {
    bit          push;
    bit          wf;
    logic [31:0] pc;
    logic [2:0]  fl;
    bit          exp_err;
    int          exp_lat;
    logic [19:0] exp_sp;
    logic [31:0] exp_pc;
    logic [2:0]  exp_fl;
  } vec_t;

  task automatic queue_accesses(input vec_t v);
    int n;
    n = v.wf ? 3 : 2;
    if (v.push) begin
      if (v.wf) exp_q.push_back('{1'b1, m_sp - 20'd0, {13'b0, v.fl}});
      exp_q.push_back('{1'b1, m_sp - 20'(n - 2), v.pc[31:16]});
      exp_q.push_back('{1'b1, m_sp - 20'(n - 1), v.pc[15:0]});
      m_sp = m_sp - 20'(n);
    end else begin
      for (int i = 1; i <= n; i++) exp_q.push_back('{1'b0, m_sp + 20'(i), 16'h0});
      m_sp = m_sp + 20'(n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    if (!v.exp_err) queue_accesses(v);
    @(negedge clk);
    push_req   = v.push;
    pop_req    = !v.push;
    with_flags = v.wf;
    pc_in      = v.pc;
    flags_in   = v.fl;
    @(posedge clk); #1;                       // E0 sampled, now in cycle E0+1
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", idx), {31'b0, err}, 32'd1);
      chk($sformatf("v%0d_err_busy", idx), {31'b0, busy}, 32'd0);
      chk($sformatf("v%0d_err_memreq", idx), {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_err_pulse", idx), {31'b0, err}, 32'd0);
    end else begin
      chk($sformatf("v%0d_busy", idx), {31'b0, busy}, 32'd1);
      cyc = 1;
      while (!done && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
      chk($sformatf("v%0d_queue_drained", idx), 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", idx), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d_idle", idx), {31'b0, busy}, 32'd0);
    end
    chk($sformatf("v%0d_sp", idx), {12'b0, sp_out}, {12'b0, v.exp_sp});
    chk($sformatf("v%0d_pc_out", idx), pc_out, v.exp_pc);
    chk($sformatf("v%0d_flags_out", idx), {29'b0, flags_out}, {29'b0, v.exp_fl});
  endtask

  vec_t vecs[17];
  vec_t v;
  int   cyc;

  initial begin
    //            push wf  pc            fl    err lat sp         pc_out        fl_out
    vecs[0]  = '{1, 0, 32'h1234_ABCD, 3'd0, 0, 3, 20'hFFFFD, 32'h0000_0000, 3'd0};
    vecs[1]  = '{0, 1, 32'h0,         3'd0, 1, 0, 20'hFFFFD, 32'h0000_0000, 3'd0};
    vecs[2]  = '{0, 0, 32'h0,         3'd0, 0, 3, 20'hFFFFF, 32'h1234_ABCD, 3'd0};
    vecs[3]  = '{1, 1, 32'h0000_0100, 3'd5, 0, 4, 20'hFFFFC, 32'h1234_ABCD, 3'd0};
    vecs[4]  = '{0, 1, 32'h0,         3'd0, 0, 4, 20'hFFFFF, 32'h0000_0100, 3'd5};
    vecs[5]  = '{0, 0, 32'h0,         3'd0, 1, 0, 20'hFFFFF, 32'h0000_0100, 3'd5};
    vecs[6]  = '{0, 1, 32'h0,         3'd0, 1, 0, 20'hFFFFF, 32'h0000_0100, 3'd5};
    vecs[7]  = '{1, 1, 32'hDEAD_BEEF, 3'd2, 0, 4, 20'hFFFFC, 32'h0000_0100, 3'd5};
    vecs[8]  = '{1, 1, 32'hCAFE_F00D, 3'd7, 0, 4, 20'hFFFF9, 32'h0000_0100, 3'd5};
    vecs[9]  = '{1, 0, 32'h89AB_CDEF, 3'd0, 0, 3, 20'hFFFF7, 32'h0000_0100, 3'd5};
    vecs[10] = '{1, 1, 32'h1111_2222, 3'd1, 1, 0, 20'hFFFF7, 32'h0000_0100, 3'd5};
    vecs[11] = '{1, 0, 32'h0BAD_F00D, 3'd0, 0, 3, 20'hFFFF5, 32'h0000_0100, 3'd5};
    vecs[12] = '{1, 0, 32'h3333_4444, 3'd0, 1, 0, 20'hFFFF5, 32'h0000_0100, 3'd5};
    vecs[13] = '{0, 0, 32'h0,         3'd0, 0, 3, 20'hFFFF7, 32'h0BAD_F00D, 3'd5};
    vecs[14] = '{0, 0, 32'h0,         3'd0, 0, 3, 20'hFFFF9, 32'h89AB_CDEF, 3'd5};
    vecs[15] = '{0, 1, 32'h0,         3'd0, 0, 4, 20'hFFFFC, 32'hCAFE_F00D, 3'd7};
    vecs[16] = '{0, 1, 32'h0,         3'd0, 0, 4, 20'hFFFFF, 32'hDEAD_BEEF, 3'd2};

    for (int i = 0; i < 32; i++) tb_mem[i] = 16'h0;
    rst = 1'b0; push_req = 0; pop_req = 0; with_flags = 0;
    pc_in = 32'h0; flags_in = 3'h0; mem_ready = 1'b1;
    m_sp = 20'hFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_addr", {12'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_flags_out", {29'b0, flags_out}, 32'd0);
    chk("rst_sp", {12'b0, sp_out}, 32'h000FFFFF);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Push and pop together (push wins) with three wait cycles in PUSH_H
    exp_q.push_back('{1'b1, 20'hFFFFF, 16'h5555});
    exp_q.push_back('{1'b1, 20'hFFFFE, 16'hAAAA});
    m_sp = 20'hFFFFD;
    @(negedge clk);
    push_req = 1'b1; pop_req = 1'b1; with_flags = 1'b0; pc_in = 32'h5555_AAAA;
    @(posedge clk); #1;
    push_req = 1'b0; pop_req = 1'b0; mem_ready = 1'b0;
    chk("dual_push_we", {31'b0, mem_we}, 32'd1);
    chk("dual_push_addr", {12'b0, mem_addr}, 32'h000FFFFF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("wait_addr", {12'b0, mem_addr}, 32'h000FFFFF);
      chk("wait_wdata", {16'b0, mem_wdata}, 32'h00005555);
      chk("wait_req", {31'b0, mem_req}, 32'd1);
    end
    mem_ready = 1'b1;
    cyc = 4;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("wait_latency", 32'(cyc), 32'd6);
    @(posedge clk); #1;
    chk("dual_pop_dropped_busy", {31'b0, busy}, 32'd0);
    chk("dual_sp", {12'b0, sp_out}, 32'h000FFFFD);
    chk("push_keeps_pc_out", pc_out, 32'hDEAD_BEEF);

    // Reset asserted while in POP_H
    exp_q.push_back('{1'b0, 20'hFFFFE, 16'h0});
    exp_q.push_back('{1'b0, 20'hFFFFF, 16'h0});
    @(negedge clk);
    pop_req = 1'b1; with_flags = 1'b0;
    @(posedge clk); #1;
    pop_req = 1'b0;
    @(posedge clk); #1;                       // now in POP_H
    chk("poph_busy", {31'b0, busy}, 32'd1);
    chk("poph_addr", {12'b0, mem_addr}, 32'h000FFFFF);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_sp", {12'b0, sp_out}, 32'h000FFFFF);
    chk("abort_pc_out", pc_out, 32'd0);
    exp_q.delete();
    m_sp = 20'hFFFFF;
    @(negedge clk); rst = 1'b1;

    v = '{1, 0, 32'h7777_8888, 3'd0, 0, 3, 20'hFFFFD, 32'h0, 3'd0};
    run_vec(v, 100);
    v = '{0, 0, 32'h0, 3'd0, 0, 3, 20'hFFFFF, 32'h7777_8888, 3'd0};
    run_vec(v, 101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pc_stack_unit

`default_nettype wire

// File: doc/pc_stack_unit.md
# pc_stack_unit

Saves and restores the 32-bit return PC (and optionally the 3-bit CCR) on the data-memory stack as 16-bit words. It is used on CALL/INT to write the PC out, and on RET/RTI to read it back and reassemble it. It owns the stack pointer and sits beside the memory stage. While it is busy it stalls the pipeline.

## Interface
Parameters:
- ADDR_W, 20: data-memory word-address width.
- SP_INIT, 20'hFFFFF: stack pointer reset value (empty-stack top).
- SP_LIMIT, 20'h00800: lowest legal stack address.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- push_req  in  1  save request (CALL/INT); sampled only in IDLE.
- pop_req  in  1  restore request (RET/RTI); sampled only in IDLE.
- with_flags  in  1  when high with a request, a CCR word is included (INT/RTI).
- pc_in  in  32  PC to save; captured with push_req.
- flags_in  in  3  CCR to save; captured with push_req.
- mem_req  out  1  memory access valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  16  write word.
- mem_rdata  in  16  read word; valid in a cycle where mem_req, !mem_we and mem_ready are all high.
- mem_ready  in  1  access completes at the posedge where it is high with mem_req.
- busy  out  1  high in every non-IDLE state (pipeline stall).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle overflow/underflow pulse; no memory access is made.
- pc_out  out  32  restored PC.
- flags_out  out  3  restored CCR.
- sp_out  out  ADDR_W  current SP.

## Operation
- States: IDLE, PUSH_F, PUSH_H, PUSH_L, POP_L, POP_H, POP_F, DONE.
- IDLE, push_req=1:
  - Compute n = 2 + with_flags.
  - If SP − n + 1 < SP_LIMIT: pulse err and stay in IDLE.
  - Otherwise latch pc_in, flags_in and with_flags, then go to PUSH_F if with_flags, else PUSH_H.
- IDLE, pop_req=1 (and push_req=0):
  - If SP + n > SP_INIT: pulse err and stay in IDLE.
  - Otherwise go to POP_L.
- If push_req and pop_req are high together, push wins and pop is dropped.
- Requests arriving outside IDLE are ignored.
- Push order, stack grows downward, one word per state. Each state writes at SP, decrements SP, and advances on mem_ready:
  - PUSH_F writes {13'b0, flags}.
  - PUSH_H writes PC[31:16].
  - PUSH_L writes PC[15:0].
- Pop is the exact mirror. Each state increments SP first and reads at SP+1; the registered SP updates on completion:
  - POP_L loads pc_out[15:0].
  - POP_H loads pc_out[31:16].
  - POP_F (only if with_flags) loads flags_out from mem_rdata[2:0].
- The last word goes to DONE, which asserts done for one cycle and then returns to IDLE.
- pc_out and flags_out hold until the next successful pop. A push does not alter them.
- SP arithmetic is unsigned ADDR_W. The err checks guarantee that SP never wraps.
- mem_req=0 in IDLE and DONE.

## Timing
- Reset values:
  - SP = SP_INIT, state = IDLE.
  - mem_req, mem_we, busy, done and err = 0.
  - mem_addr = 0, mem_wdata = 0, pc_out = 0, flags_out = 0.
- Reset mid-operation: abort immediately, drop mem_req, and restore SP to SP_INIT. Partial pushes are not undone in memory.
- Timing below takes request sampled at edge E0 with zero-wait memory (mem_ready=1):
  - 2-word op: accesses in cycles E0+1 and E0+2, done in E0+3, busy in E0+1..E0+3.
  - 3-word op: done in E0+4.
- Each wait cycle (mem_ready=0) extends the current state by one cycle. Address and data stay stable while waiting.
- err is asserted in cycle E0+1, with busy remaining 0.
- A request held high after done is accepted again in IDLE. Requesters must drop the request on done.

## Structure
- Shared package `pc_stack_pkg`: the state enum, SP_INIT/SP_LIMIT defaults, and word-count constants (PC_WORDS=2, INT_WORDS=3).
- Single module, no sub-module. Keep the SP register and the FSM in the same always block, plus a combinational address/data mux.

## Test plan
- Push pc_in=32'h1234_ABCD, with_flags=0, from reset: writes 16'h1234 @FFFFF then 16'hABCD @FFFFE; SP=FFFFD; done at E0+3.
- Then pop with with_flags=0: reads @FFFFE then @FFFFF; pc_out=32'h1234_ABCD; SP=FFFFF; done at E0+3.
- INT push of PC 32'h0000_0100 with flags 3'b101, then RTI pop: three writes/reads in mirror order; flags_out=3'b101; done at E0+4.
- Pop on empty stack (SP=FFFFF): err pulses at E0+1, no mem_req, SP unchanged. Push with SP=SP_LIMIT+1, with_flags=1: err pulses.
- mem_ready low for 3 cycles during PUSH_H: mem_addr/mem_wdata stay stable, done delayed by 3; push_req and pop_req both high selects push.
- Assert rst low during POP_H: mem_req=0, busy=0, and SP=SP_INIT at once; after release, the next push starts cleanly.
